// File: rtl/lcd1602_emu.sv
// lcd1602_emu: HD44780/LCD1602 bus responder with 80-byte DDRAM, busy timer, bus reads and viewer port
module lcd1602_emu #(
  parameter int BUSY_SHORT = 1850,
  parameter int BUSY_LONG = 76000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_q,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic       lcd_rw,
  output logic [7:0] rd_q,
  output logic       rd_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [5:0] shift_ofs,
  input  logic [6:0] view_addr,
  output logic [7:0] view_data,
  output logic       ignored,
  output logic       addr_err
);
  localparam int CW = $clog2(BUSY_LONG > BUSY_SHORT ? BUSY_LONG : BUSY_SHORT) + 1;
  typedef enum logic [1:0] {CLEAR, EXEC, IDLE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0] s1_q, s2_q, s3_q;
  logic [6:0] ac_q, ac_d, mem_idx;
  logic [5:0] ofs_q, ofs_d;
  logic [7:0] rdata_q, rdata_d, view_q, view_d, mem_wd, bd;
  logic id_q, id_d, s_q, s_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic err_q, err_d, ign_q, ign_d, busy_q, busy_d, oe_q, oe_d, mem_we, stb, b_rs, b_rw;
  logic [7:0] mem [0:79];
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    return up ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
              : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
  endfunction
  function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic up);
    return up ? (o == 6'd39 ? 6'd0 : o + 6'd1) : (o == 6'd0 ? 6'd39 : o - 6'd1);
  endfunction
  function automatic logic [6:0] idx(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction
  function automatic logic valid(input logic [6:0] a);
    return a <= 7'h27 || (a >= 7'h40 && a <= 7'h67);
  endfunction
  assign stb = s3_q[10] & ~s2_q[10];
  assign {b_rw, b_rs, bd} = s3_q[9:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ac_d = ac_q;
    ofs_d = ofs_q;
    id_d = id_q;
    s_d = s_q;
    disp_d = disp_q;
    cur_d = cur_q;
    blink_d = blink_q;
    err_d = err_q;
    ign_d = stb & ~b_rw & (state_q != IDLE);
    mem_we = 1'b0;
    mem_idx = idx(ac_q);
    mem_wd = bd;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_idx = cnt_q[6:0];
      mem_wd = 8'h20;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(79)) begin
        state_d = EXEC;
        cnt_d = CW'(BUSY_LONG - 1);
        ac_d = '0;
        id_d = 1'b1;
        ofs_d = '0;
      end
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) state_d = IDLE;
    end else if (stb && b_rw && b_rs) begin
      ac_d = ac_step(ac_q, id_q);
    end else if (stb && !b_rw) begin
      state_d = EXEC;
      cnt_d = CW'(BUSY_SHORT - 1);
      if (b_rs) begin
        mem_we = 1'b1;
        ac_d = ac_step(ac_q, id_q);
        if (s_q) ofs_d = ofs_step(ofs_q, id_q);
      end else if (bd[7]) begin
        if (valid(bd[6:0])) ac_d = bd[6:0];
        else err_d = 1'b1;
      end else if (bd[6:5] == 2'b00) begin
        if (bd[4]) begin
          if (bd[3]) ofs_d = ofs_step(ofs_q, bd[2]);
          else ac_d = ac_step(ac_q, bd[2]);
        end else if (bd[3]) begin
          {disp_d, cur_d, blink_d} = bd[2:0];
        end else if (bd[2]) begin
          {id_d, s_d} = bd[1:0];
        end else if (bd[1]) begin
          ac_d = '0;
          ofs_d = '0;
          cnt_d = CW'(BUSY_LONG - 1);
        end else if (bd[0]) begin
          state_d = CLEAR;
          cnt_d = '0;
        end
      end
    end
    busy_d = state_d != IDLE;
    oe_d = s2_q[10] & s2_q[9];
    rdata_d = oe_d ? (s2_q[8] ? mem[idx(ac_q)] : {busy_q, ac_q}) : 8'h00;
    view_d = valid(view_addr) ? mem[idx(view_addr)] : 8'h20;
  end
  always_ff @(posedge clk) if (mem_we) mem[mem_idx] <= mem_wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      ac_q <= '0;
      ofs_q <= '0;
      id_q <= 1'b1;
      s_q <= 1'b0;
      disp_q <= 1'b0;
      cur_q <= 1'b0;
      blink_q <= 1'b0;
      err_q <= 1'b0;
      ign_q <= 1'b0;
      busy_q <= 1'b0;
      oe_q <= 1'b0;
      rdata_q <= '0;
      view_q <= 8'h20;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s1_q <= {lcd_en, lcd_rw, lcd_rs, lcd_q};
      s2_q <= s1_q;
      s3_q <= s2_q;
      ac_q <= ac_d;
      ofs_q <= ofs_d;
      id_q <= id_d;
      s_q <= s_d;
      disp_q <= disp_d;
      cur_q <= cur_d;
      blink_q <= blink_d;
      err_q <= err_d;
      ign_q <= ign_d;
      busy_q <= busy_d;
      oe_q <= oe_d;
      rdata_q <= rdata_d;
      view_q <= view_d;
    end
  end
  assign rd_q = rdata_q;
  assign rd_oe = oe_q;
  assign busy = busy_q;
  assign ac = ac_q;
  assign disp_on = disp_q;
  assign cursor_on = cur_q;
  assign blink_on = blink_q;
  assign shift_ofs = ofs_q;
  assign view_data = view_q;
  assign ignored = ign_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_lcd1602_emu.sv
// tb_lcd1602_emu: randomized directed bench for lcd1602_emu against a linear-position DDRAM model
module tb_lcd1602_emu;
  localparam int S = 20;
  localparam int L = 100;
  localparam int SYNC = 3;
  logic clk = 1'b0, rst_n = 1'b1, lcd_rs = 1'b0, lcd_en = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_q = '0, rd_q, view_data;
  logic rd_oe, busy, disp_on, cursor_on, blink_on, ignored, addr_err;
  logic [6:0] ac, view_addr = '0;
  logic [5:0] shift_ofs;
  int checks = 0, failures = 0, ign_n = 0;
  logic [7:0] m_mem [80];
  logic [6:0] m_ac;
  bit m_id, m_s, m_d, m_c, m_b, m_err;
  int m_ofs;
  lcd1602_emu #(.BUSY_SHORT(S), .BUSY_LONG(L)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_q(lcd_q), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
    .rd_q(rd_q), .rd_oe(rd_oe), .busy(busy), .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .shift_ofs(shift_ofs), .view_addr(view_addr), .view_data(view_data),
    .ignored(ignored), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ignored) ign_n++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pos_of(input logic [6:0] a);
    return a >= 7'h40 ? int'(a) - 64 + 40 : int'(a);
  endfunction
  function automatic logic [6:0] addr_of(input int p);
    return p < 40 ? 7'(p) : 7'(p - 40 + 64);
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_s = 0; m_ofs = 0; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
  endfunction
  function automatic void m_step(input bit up);
    m_ac = addr_of((pos_of(m_ac) + (up ? 1 : 79)) % 80);
  endfunction
  function automatic void m_shift(input bit up);
    m_ofs = (m_ofs + (up ? 1 : 39)) % 40;
  endfunction
  function automatic void model_wr(input bit rs, input logic [7:0] d);
    int v;
    v = int'(d);
    if (rs) begin
      m_mem[pos_of(m_ac)] = d;
      m_step(m_id);
      if (m_s) m_shift(m_id);
    end else if (v >= 128) begin
      if (v - 128 < 40 || (v - 128 >= 64 && v - 128 < 104)) m_ac = 7'(v - 128);
      else m_err = 1;
    end else if (v >= 32) begin
    end else if (v >= 16) begin
      if (d[3]) m_shift(d[2]);
      else m_step(d[2]);
    end else if (v >= 8) begin
      {m_d, m_c, m_b} = d[2:0];
    end else if (v >= 4) begin
      {m_id, m_s} = d[1:0];
    end else if (v >= 2) begin
      m_ac = 0; m_ofs = 0;
    end else if (v == 1) begin
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      m_ac = 0; m_id = 1; m_ofs = 0;
    end
  endfunction
  task automatic strobe(input bit rs, input bit rw, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = rw; lcd_q = d; lcd_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_en = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (4) @(posedge clk);
    #1;
    while (busy && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic measure(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((busy || n < 5) && n < 5000);
  endtask
  task automatic op(input bit rs, input logic [7:0] d);
    strobe(rs, 1'b0, d);
    wait_idle(2000);
    model_wr(rs, d);
  endtask
  task automatic view(input string tag, input logic [6:0] a, input logic [7:0] exp);
    view_addr = a;
    @(posedge clk); #1;
    chk(tag, view_data, exp);
  endtask
  task automatic scan(input string tag);
    for (int p = 0; p < 80; p++) view(tag, addr_of(p), m_mem[p]);
  endtask
  task automatic rd_begin(input bit rs);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic rd_end();
    lcd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 lcd_rw = 1'b0;
  endtask
  task automatic rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) op(1, 8'($urandom));
    else if (r == 5) op(0, 8'h80 | 8'(addr_of($urandom_range(0, 79))));
    else if (r == 6) op(0, 8'h04 | 8'($urandom_range(0, 3)));
    else if (r == 7) op(0, 8'h10 | 8'($urandom_range(0, 15)));
    else if (r == 8) op(0, 8'h08 | 8'($urandom_range(0, 7)));
    else op(0, 8'h20 + 8'($urandom_range(0, 95)));
  endtask
  initial begin
    int n, ign0;
    logic [6:0] a0;
    m_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ac", ac, 0);
    chk("rst_view", view_data, 8'h20);
    chk("rst_misc", {rd_q, rd_oe, disp_on, cursor_on, blink_on, shift_ofs, ignored, addr_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("fill_busy", busy, 1);
    wait_idle(2000);
    op(0, 8'h38); op(0, 8'h0C); op(0, 8'h06); op(0, 8'h01); op(0, 8'h80); op(1, 8'h41);
    view("first_char", 7'h00, 8'h41);
    chk("first_ac", ac, 7'h01);
    chk("first_disp", {disp_on, cursor_on}, 2'b10);
    op(0, 8'hA7); op(1, 8'h5A);
    view("line1_end", 7'h27, 8'h5A);
    chk("wrap_line2", ac, 7'h40);
    view("view_invalid", 7'h28, 8'h20);
    op(0, 8'h04); op(0, 8'h80); op(1, 8'h33);
    chk("dec_wrap", ac, 7'h67);
    op(0, 8'h06);
    a0 = m_ac;
    ign0 = ign_n;
    strobe(1, 0, 8'h77);
    repeat (7) @(posedge clk);
    #1;
    strobe(1, 0, 8'h99);
    wait_idle(2000);
    model_wr(1, 8'h77);
    chk("ignored_pulses", ign_n - ign0, 1);
    view("ignored_keep0", a0, 8'h77);
    view("ignored_keep1", m_ac, m_mem[pos_of(m_ac)]);
    chk("ignored_ac", ac, m_ac);
    strobe(0, 0, 8'h0F);
    measure(n);
    model_wr(0, 8'h0F);
    chk("busy_short_len", 32'(n - SYNC >= S - 3 && n - SYNC <= S + 3), 1);
    for (int i = 0; i < 40; i++) rand_op();
    scan("rand_ddram");
    chk("rand_ac", ac, m_ac);
    chk("rand_ofs", shift_ofs, m_ofs);
    chk("rand_dcb", {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b});
    strobe(0, 0, 8'h01);
    measure(n);
    model_wr(0, 8'h01);
    chk("busy_clear_len", 32'(n - SYNC >= 80 + L - 3 && n - SYNC <= 80 + L + 3), 1);
    chk("clear_ac", ac, 0);
    scan("clear_ddram");
    op(0, 8'h85);
    op(0, 8'hA8);
    chk("addr_err_set", addr_err, 1);
    chk("addr_err_ac", ac, 7'h05);
    op(0, 8'hC0);
    chk("addr_c0_ac", ac, 7'h40);
    chk("addr_err_sticky", addr_err, 1);
    strobe(0, 0, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    rd_begin(0);
    chk("rd_oe_busy", rd_oe, 1);
    chk("rd_bf_ac", rd_q, {1'b1, m_ac});
    rd_end();
    wait_idle(2000);
    model_wr(0, 8'h01);
    op(0, 8'h85); op(1, 8'h5C); op(0, 8'h85);
    rd_begin(1);
    chk("rd_data", rd_q, 8'h5C);
    rd_end();
    m_step(m_id);
    chk("rd_step_ac", ac, m_ac);
    chk("rd_no_busy", busy, 0);
    op(0, 8'hE0); op(1, 8'h11); op(1, 8'h12);
    for (int i = 0; i < 8; i++) rand_op();
    strobe(0, 0, 8'h01);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr_busy", busy, 0);
    chk("midclr_ac", ac, 0);
    chk("midclr_view", view_data, 8'h20);
    chk("midclr_err", addr_err, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(2000);
    scan("refill_ddram");
    chk("refill_ac", ac, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
